// File: rtl/my_mod_seq_ctrl.sv
// Modulation sequencer for the IRIS error-signal generator.
// Produces the square-wave modulation status and a one-cycle trigger on each
// running edge. Host configuration is double-buffered: validated writes land
// in a pending set and are copied to the active set at a pair boundary, so an
// L/H acquisition pair never mixes settings. A watchdog flags missing
// step-sync returns from the generator.
module my_mod_seq_ctrl #(
  parameter int unsigned DEF_HALF = 1000,
  parameter int unsigned DEF_WAIT = 100,
  parameter int unsigned DEF_AVG  = 4,
  parameter int unsigned OVH      = 6,
  parameter int unsigned WD_EDGES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_cfg_wr,
  input  logic [31:0]        i_half_cnt,
  input  logic [31:0]        i_wait_cnt,
  input  logic [4:0]         i_avg_sel,
  input  logic signed [31:0] i_err_offset,
  input  logic               i_polarity,
  input  logic               i_step_sync,
  output logic               o_mod,
  output logic               o_trig,
  output logic [31:0]        o_wait_cnt,
  output logic [31:0]        o_avg_sel,
  output logic signed [31:0] o_err_offset,
  output logic               o_polarity,
  output logic               o_cfg_busy,
  output logic               o_cfg_err,
  output logic [31:0]        o_pair_cnt,
  output logic               o_timeout
);

  localparam int unsigned   WDW    = $clog2(WD_EDGES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(WD_EDGES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // One complete generator setting; active and pending copies share this shape.
  typedef struct packed {
    logic [31:0]        half;
    logic [31:0]        wait_cnt;
    logic [4:0]         avg;
    logic signed [31:0] offset;
    logic               pol;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    half:     32'(DEF_HALF),
    wait_cnt: 32'(DEF_WAIT),
    avg:      5'(DEF_AVG),
    offset:   32'sd0,
    pol:      1'b0
  };

  state_e         state_q, state_d;
  logic [31:0]    hc_q, hc_d;
  logic           trig_q, trig_d;
  cfg_t           act_q, act_d;
  cfg_t           pend_q, pend_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [31:0]    pair_q, pair_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;

  logic [33:0] wr_need;
  logic        wr_ok;
  logic        running;
  logic        edge_run;
  logic        hl_edge;
  logic        start;
  logic        apply;
  logic [31:0] reload_half;

  // Write validation and the timing events shared by the FSM and datapath.
  always_comb begin
    // The budget is summed in 34 bits so a huge wait count cannot wrap and
    // sneak under the half-period.
    wr_need     = {2'b00, i_wait_cnt} + (34'd1 << i_avg_sel) + 34'(OVH);
    wr_ok       = (i_half_cnt >= 32'd16) && (i_avg_sel <= 5'd20) &&
                  (wr_need <= {2'b00, i_half_cnt});
    running     = (state_q == ST_HIGH) || (state_q == ST_LOW);
    edge_run    = running && i_en && (hc_q == 32'd0);
    hl_edge     = edge_run && (state_q == ST_HIGH);
    start       = (state_q == ST_IDLE) && i_en;
    apply       = busy_q && (hl_edge || (state_q == ST_IDLE));
    // A set applied at this edge already governs the reload it coincides with.
    reload_half = apply ? pend_q.half : act_q.half;
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples the pre-edge values, independent of block order.
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: disable always wins, otherwise toggle when hc expires.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches
    // for any path that does not assign state_d explicitly.
    state_d = state_q;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HIGH;
        ST_HIGH: if (hc_q == 32'd0) state_d = ST_LOW;
        ST_LOW:  if (hc_q == 32'd0) state_d = ST_HIGH;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: mod level follows the state; trig is the registered edge pulse.
  always_comb begin
    o_mod  = (state_q == ST_HIGH);
    o_trig = trig_q;
  end

  // Half-period counter, trigger, config buffers, pair counter and watchdog.
  always_comb begin
    hc_d      = hc_q;
    trig_d    = edge_run;
    act_d     = apply ? pend_q : act_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    err_d     = err_q;
    pair_d    = pair_q + {31'd0, hl_edge};
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;

    if (!i_en)                 hc_d = 32'd0;
    else if (start || edge_run) hc_d = reload_half - 32'd1;
    else if (running)          hc_d = hc_q - 32'd1;

    // A boundary consumes the old pending set; a same-cycle valid write
    // re-arms busy so the new set waits for the following boundary.
    if (apply) busy_d = 1'b0;
    if (i_cfg_wr) begin
      err_d = !wr_ok;
      if (wr_ok) begin
        pend_d = '{half: i_half_cnt, wait_cnt: i_wait_cnt, avg: i_avg_sel,
                   offset: i_err_offset, pol: i_polarity};
        busy_d = 1'b1;
      end
    end

    // Step-sync beats a same-cycle trigger; leaving the run clears the count
    // but keeps the flag for the host to see.
    if (i_step_sync) begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (!i_en || !running) begin
      wd_cnt_d = '0;
    end else if (edge_run && (wd_cnt_q != WD_MAX)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q + 1'b1 == WD_MAX) timeout_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hc_q      <= 32'd0;
      trig_q    <= 1'b0;
      act_q     <= CFG_RST;
      pend_q    <= CFG_RST;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      pair_q    <= 32'd0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      trig_q    <= trig_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      pair_q    <= pair_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Status outputs straight from registers.
  always_comb begin
    o_wait_cnt   = act_q.wait_cnt;
    o_avg_sel    = {27'd0, act_q.avg};
    o_err_offset = act_q.offset;
    o_polarity   = act_q.pol;
    o_cfg_busy   = busy_q;
    o_cfg_err    = err_q;
    o_pair_cnt   = pair_q;
    o_timeout    = timeout_q;
  end

endmodule

// File: tb/tb_my_mod_seq_ctrl.sv
// Self-checking bench for my_mod_seq_ctrl: hand-written run sequences for the
// multi-cycle behaviour, then a table of host writes applied while idle.
module tb_my_mod_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               cfg_wr;
  logic [31:0]        half_cnt;
  logic [31:0]        wait_cnt;
  logic [4:0]         avg_sel;
  logic signed [31:0] err_offset;
  logic               polarity;
  logic               step_sync;
  logic               mod;
  logic               trig;
  logic [31:0]        o_wait;
  logic [31:0]        o_avg;
  logic signed [31:0] o_off;
  logic               o_pol;
  logic               busy;
  logic               cerr;
  logic [31:0]        pair;
  logic               tmo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  my_mod_seq_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_cfg_wr     (cfg_wr),
    .i_half_cnt   (half_cnt),
    .i_wait_cnt   (wait_cnt),
    .i_avg_sel    (avg_sel),
    .i_err_offset (err_offset),
    .i_polarity   (polarity),
    .i_step_sync  (step_sync),
    .o_mod        (mod),
    .o_trig       (trig),
    .o_wait_cnt   (o_wait),
    .o_avg_sel    (o_avg),
    .o_err_offset (o_off),
    .o_polarity   (o_pol),
    .o_cfg_busy   (busy),
    .o_cfg_err    (cerr),
    .o_pair_cnt   (pair),
    .o_timeout    (tmo)
  );

  typedef struct {
    logic [31:0]        half;
    logic [31:0]        wcnt;
    logic [4:0]         avg;
    logic signed [31:0] off;
    logic               pol;
    logic               ok;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock, then sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until o_trig is seen; n = ticks taken, or -1 if the budget expires.
  task automatic wait_trig(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (trig) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] h, input logic [31:0] w, input logic [4:0] a,
                          input logic signed [31:0] o, input logic p);
    half_cnt   = h;
    wait_cnt   = w;
    avg_sel    = a;
    err_offset = o;
    polarity   = p;
    cfg_wr     = 1'b1;
    tick();
    cfg_wr     = 1'b0;
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_mod"},     {31'd0, mod},  32'd0);
    check({tag, "_trig"},    {31'd0, trig}, 32'd0);
    check({tag, "_wait"},    o_wait,        32'd100);
    check({tag, "_avg"},     o_avg,         32'd4);
    check({tag, "_off"},     o_off,         32'd0);
    check({tag, "_pol"},     {31'd0, o_pol}, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_err"},     {31'd0, cerr}, 32'd0);
    check({tag, "_pair"},    pair,          32'd0);
    check({tag, "_timeout"}, {31'd0, tmo},  32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] exp_wait;
    logic [31:0] exp_avg;
    logic [31:0] exp_off;
    logic [31:0] exp_pol;

    rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0; step_sync = 1'b0;
    half_cnt = '0; wait_cnt = '0; avg_sel = '0; err_offset = '0; polarity = 1'b0;
    #22;
    check_defaults("reset");
    rst_n = 1'b1;
    tick();
    check_defaults("post_reset");

    // Default run: 1000-clock halves, no trigger on the IDLE->HIGH entry.
    en = 1'b1;
    tick();
    check("entry_mod",  {31'd0, mod},  32'd1);
    check("entry_trig", {31'd0, trig}, 32'd0);
    wait_trig(3000, n);
    check("def_high_len", n, 32'd1000);
    check("def_hl_mod",   {31'd0, mod}, 32'd0);
    check("def_hl_pair",  pair, 32'd1);
    wait_trig(3000, n);
    check("def_low_len",  n, 32'd1000);
    check("def_lh_mod",   {31'd0, mod}, 32'd1);

    // Mid-HIGH write waits for the HIGH->LOW boundary.
    repeat (10) tick();
    do_write(32'd200, 32'd50, 5'd3, -32'sd3, 1'b1);
    check("mid_busy",     {31'd0, busy}, 32'd1);
    check("mid_err",      {31'd0, cerr}, 32'd0);
    check("mid_wait_old", o_wait, 32'd100);
    wait_trig(3000, n);
    check("mid_rest_high", n, 32'd989);
    check("mid_apply_mod",  {31'd0, mod}, 32'd0);
    check("mid_apply_busy", {31'd0, busy}, 32'd0);
    check("mid_apply_wait", o_wait, 32'd50);
    check("mid_apply_avg",  o_avg, 32'd3);
    check("mid_apply_off",  o_off, 32'hFFFF_FFFD);
    check("mid_apply_pol",  {31'd0, o_pol}, 32'd1);
    check("mid_apply_pair", pair, 32'd2);
    wait_trig(3000, n);
    check("new_low_len", n, 32'd200);
    check("new_lh_mod",  {31'd0, mod}, 32'd1);

    // Rejected write, then a valid one clearing the error, then a write
    // coincident with the HIGH->LOW boundary.
    do_write(32'd100, 32'd90, 5'd4, 32'sd1, 1'b0);
    check("bad_err",  {31'd0, cerr}, 32'd1);
    check("bad_busy", {31'd0, busy}, 32'd0);
    check("bad_wait", o_wait, 32'd50);
    check("bad_avg",  o_avg, 32'd3);
    do_write(32'd300, 32'd10, 5'd2, -32'sd5, 1'b1);
    check("good_err",  {31'd0, cerr}, 32'd0);
    check("good_busy", {31'd0, busy}, 32'd1);
    check("good_wait", o_wait, 32'd50);
    repeat (197) tick();
    check("pre_edge_trig", {31'd0, trig}, 32'd0);
    do_write(32'd120, 32'd20, 5'd5, 32'sd7, 1'b0);
    check("coin_trig", {31'd0, trig}, 32'd1);
    check("coin_mod",  {31'd0, mod}, 32'd0);
    check("coin_wait", o_wait, 32'd10);
    check("coin_avg",  o_avg, 32'd2);
    check("coin_off",  o_off, 32'hFFFF_FFFB);
    check("coin_busy", {31'd0, busy}, 32'd1);
    check("coin_pair", pair, 32'd3);
    wait_trig(3000, n);
    check("coin_low_len",  n, 32'd300);
    check("coin_lh_wait",  o_wait, 32'd10);
    check("coin_lh_busy",  {31'd0, busy}, 32'd1);
    wait_trig(3000, n);
    check("next_high_len", n, 32'd300);
    check("next_wait",     o_wait, 32'd20);
    check("next_avg",      o_avg, 32'd5);
    check("next_off",      o_off, 32'd7);
    check("next_pol",      {31'd0, o_pol}, 32'd0);
    check("next_busy",     {31'd0, busy}, 32'd0);
    check("next_pair",     pair, 32'd4);
    // Seven running edges so far with no step-sync.
    check("wd_edge7", {31'd0, tmo}, 32'd0);
    wait_trig(3000, n);
    check("set3_low_len", n, 32'd120);
    check("wd_edge8",     {31'd0, tmo}, 32'd1);
    step_sync = 1'b1;
    tick();
    step_sync = 1'b0;
    check("wd_cleared", {31'd0, tmo}, 32'd0);

    // Pair counter wrap from all-ones.
    force dut.pair_q = 32'hFFFF_FFFF;
    #1;
    release dut.pair_q;
    wait_trig(3000, n);
    check("wrap_high_len", n, 32'd119);
    check("wrap_pair",     pair, 32'd0);
    check("wrap_timeout",  {31'd0, tmo}, 32'd0);

    // Disable mid-LOW keeps config and counters.
    repeat (5) tick();
    en = 1'b0;
    tick();
    check("dis_mod",  {31'd0, mod}, 32'd0);
    check("dis_trig", {31'd0, trig}, 32'd0);
    check("dis_wait", o_wait, 32'd20);
    check("dis_pair", pair, 32'd0);
    repeat (3) tick();
    check("idle_mod", {31'd0, mod}, 32'd0);
    en = 1'b1;
    tick();
    check("reen_mod",  {31'd0, mod}, 32'd1);
    check("reen_trig", {31'd0, trig}, 32'd0);
    wait_trig(3000, n);
    check("reen_high_len", n, 32'd120);
    check("reen_pair",     pair, 32'd1);
    wait_trig(3000, n);
    check("reen_low_len",  n, 32'd120);

    // Asynchronous reset mid-HIGH.
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_defaults("async_rst");
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("rst_idle_mod", {31'd0, mod}, 32'd0);

    // Table of host writes applied while idle.
    vecs[0] = '{half: 32'd16,        wcnt: 32'd0,         avg: 5'd0,  off: 32'sd1,  pol: 1'b1, ok: 1'b1};
    vecs[1] = '{half: 32'd15,        wcnt: 32'd0,         avg: 5'd0,  off: 32'sd2,  pol: 1'b0, ok: 1'b0};
    vecs[2] = '{half: 32'd116,       wcnt: 32'd94,        avg: 5'd4,  off: -32'sd9, pol: 1'b0, ok: 1'b1};
    vecs[3] = '{half: 32'd116,       wcnt: 32'd95,        avg: 5'd4,  off: 32'sd3,  pol: 1'b1, ok: 1'b0};
    vecs[4] = '{half: 32'hFFFF_FFFF, wcnt: 32'hFFFF_FFFF, avg: 5'd0,  off: 32'sd4,  pol: 1'b1, ok: 1'b0};
    vecs[5] = '{half: 32'd2000000,   wcnt: 32'd100,       avg: 5'd20, off: 32'sd5,  pol: 1'b1, ok: 1'b1};
    vecs[6] = '{half: 32'd2000000,   wcnt: 32'd100,       avg: 5'd21, off: 32'sd6,  pol: 1'b0, ok: 1'b0};
    vecs[7] = '{half: 32'd50,        wcnt: 32'd10,        avg: 5'd3,  off: 32'sd8,  pol: 1'b0, ok: 1'b1};
    exp_wait = 32'd100;
    exp_avg  = 32'd4;
    exp_off  = 32'd0;
    exp_pol  = 32'd0;
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].half, vecs[i].wcnt, vecs[i].avg, vecs[i].off, vecs[i].pol);
      check($sformatf("tbl%0d_err", i),  {31'd0, cerr}, {31'd0, !vecs[i].ok});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].ok});
      tick();
      if (vecs[i].ok) begin
        exp_wait = vecs[i].wcnt;
        exp_avg  = {27'd0, vecs[i].avg};
        exp_off  = vecs[i].off;
        exp_pol  = {31'd0, vecs[i].pol};
      end
      check($sformatf("tbl%0d_applied", i), {31'd0, busy}, 32'd0);
      check($sformatf("tbl%0d_wait", i), o_wait, exp_wait);
      check($sformatf("tbl%0d_avg", i),  o_avg,  exp_avg);
      check($sformatf("tbl%0d_off", i),  o_off,  exp_off);
      check($sformatf("tbl%0d_pol", i),  {31'd0, o_pol}, exp_pol);
    end

    // Last table set (half 50) governs a fresh run.
    en = 1'b1;
    tick();
    wait_trig(500, n);
    check("tbl_run_high_len", n, 32'd50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
